// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multi-cycle CPU.
// It accepts one request at a time and models a word-addressed memory array
// with a fixed access latency. Each response is returned through a
// valid/ready handshake.
//
// Ports:
//   clk             - clock; all state updates on the rising edge
//   reset           - asynchronous, active-high reset
//   is_input_valid  - request present this cycle
//   is_ready        - responder can accept a request (IDLE, out of reset)
//   addr            - byte address of the request
//   mem_write       - 1 = write, 0 = read
//   din             - write data
//   is_output_valid - response present (RESPOND state)
//   is_output_ready - initiator consumes the response this cycle
//   dout            - read data; 0 for write and error responses
//   is_error        - response belongs to a misaligned request
module mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  is_input_valid,
    output logic                  is_ready,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  is_output_valid,
    input  logic                  is_output_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  is_error
);

    localparam int            LADDR_W  = DEPTH_LOG2 + 2;
    localparam int            DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]    CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [LADDR_W-1:0]      req_addr_q, req_addr_d;
    logic                    req_write_q, req_write_d;
    logic [DATA_WIDTH-1:0]   req_din_q, req_din_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    accept;
    logic                    commit;
    logic                    misaligned;
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   idx;

    // Address bits above the array are ignored, so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_WIDTH-1:LADDR_W];

    assign idx        = req_addr_q[LADDR_W-1:2];
    assign misaligned = (req_addr_q[1:0] != 2'b00);
    assign accept     = is_ready && is_input_valid;
    assign commit     = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign mem_we     = commit && req_write_q && !misaligned;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)          state_d = ACCESS;
            ACCESS:  if (cnt_q == 4'd0)   state_d = RESPOND;
            RESPOND: if (is_output_ready) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Handshake outputs. is_ready is gated by reset so that it reads 0 while
    // reset is held, even though the state register already shows IDLE.
    always_comb begin
        is_ready        = (state_q == IDLE) && !reset;
        is_output_valid = (state_q == RESPOND);
    end

    // Request latch, latency counter and response registers
    always_comb begin
        cnt_d       = cnt_q;
        req_addr_d  = req_addr_q;
        req_write_d = req_write_q;
        req_din_d   = req_din_q;
        dout_d      = dout_q;
        err_d       = err_q;

        if (accept) begin
            req_addr_d  = addr[LADDR_W-1:0];
            req_write_d = mem_write;
            req_din_d   = din;
            cnt_d       = CNT_LOAD;
        end else if (state_q == ACCESS) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                // Commit edge: a read returns the array word. Writes and
                // misaligned requests return 0.
                if (misaligned || req_write_q) begin
                    dout_d = '0;
                end else begin
                    dout_d = mem_q[idx];
                end
                err_d = misaligned;
            end
        end else if ((state_q == RESPOND) && is_output_ready) begin
            // dout keeps its last value after the handshake
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            req_din_q   <= '0;
            dout_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            req_write_q <= req_write_d;
            req_din_q   <= req_din_d;
            dout_q      <= dout_d;
            err_q       <= err_d;
        end
    end

    // Array is never cleared. A reset before the commit edge forces IDLE, so
    // an aborted write never reaches it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= req_din_q;
        end
    end

    assign dout     = dout_q;
    assign is_error = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, ready, wr, out_valid, out_ready, err;
    logic [31:0] addr, din, dout;

    logic        l1_in_valid, l1_ready, l1_wr, l1_out_valid, l1_out_ready, l1_err;
    logic [31:0] l1_addr, l1_din, l1_dout;

    mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .is_input_valid(in_valid), .is_ready(ready),
        .addr(addr), .mem_write(wr), .din(din),
        .is_output_valid(out_valid), .is_output_ready(out_ready),
        .dout(dout), .is_error(err)
    );

    mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(1)
    ) dut_l1 (
        .clk(clk), .reset(reset),
        .is_input_valid(l1_in_valid), .is_ready(l1_ready),
        .addr(l1_addr), .mem_write(l1_wr), .din(l1_din),
        .is_output_valid(l1_out_valid), .is_output_ready(l1_out_ready),
        .dout(l1_dout), .is_error(l1_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: word array indexed by (byte address / 4) mod 1024
    logic [31:0] ref_mem   [1024];
    bit          ref_known [1024];

    function automatic int ref_index(input logic [31:0] a);
        return int'((a >> 2) % 1024);
    endfunction

    // One full transaction on the LATENCY=4 instance.
    // hold: cycles the response is stalled; junk: scribble inputs during ACCESS.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int hold, input bit junk);
        int          idx;
        int          n;
        logic [31:0] exp_d;
        logic        exp_e;
        bit          know;
        logic [31:0] held;
        idx   = ref_index(a);
        exp_e = (a % 4) != 0;
        if (exp_e || w) begin
            exp_d = 32'd0;
            know  = 1'b1;
        end else begin
            exp_d = ref_mem[idx];
            know  = ref_known[idx];
        end

        @(negedge clk);
        check("ready_before_req", 32'(ready), 32'd1);
        in_valid  = 1'b1;
        addr      = a;
        wr        = w;
        din       = d;
        out_ready = (hold == 0);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && junk) begin
                in_valid = 1'($urandom_range(0, 1));
                addr     = $urandom;
                wr       = 1'($urandom_range(0, 1));
                din      = $urandom;
            end else begin
                in_valid = 1'b0;
            end
        end while (!out_valid && n < 40);
        in_valid = 1'b0;

        check("resp_latency", 32'(n), 32'(LAT + 1));
        check("resp_ready_low", 32'(ready), 32'd0);
        check("resp_err", 32'(err), 32'(exp_e));
        if (know) check("resp_dout", dout, exp_d);
        held = dout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_dout", dout, held);
            check("hold_ready", 32'(ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_ready", 32'(ready), 32'd1);
        check("post_err", 32'(err), 32'd0);
        out_ready = 1'b0;

        if (w && !exp_e) begin
            ref_mem[idx]   = d;
            ref_known[idx] = 1'b1;
        end
    endtask

    // Transaction on the LATENCY=1 instance, response consumed immediately.
    task automatic l1_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_d);
        int n;
        @(negedge clk);
        check("l1_ready", 32'(l1_ready), 32'd1);
        l1_in_valid  = 1'b1;
        l1_addr      = a;
        l1_wr        = w;
        l1_din       = d;
        l1_out_ready = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            l1_in_valid = 1'b0;
        end while (!l1_out_valid && n < 40);
        check("l1_latency", 32'(n), 32'd2);
        check("l1_dout", l1_dout, exp_d);
        @(negedge clk);
        check("l1_post_valid", 32'(l1_out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        reset        = 1'b1;
        in_valid     = 1'b0; addr = '0; wr = 1'b0; din = '0; out_ready = 1'b0;
        l1_in_valid  = 1'b0; l1_addr = '0; l1_wr = 1'b0; l1_din = '0; l1_out_ready = 1'b0;
        for (int i = 0; i < 1024; i++) ref_known[i] = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(ready), 32'd1);

        // Directed cases
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 3, 1'b0);
        do_req(1'b1, 32'h0, 32'h11111111, 0, 1'b0);
        do_req(1'b0, 32'h1000, 32'h0, 0, 1'b0);
        do_req(1'b1, 32'h4, 32'hA5A5A5A5, 0, 1'b0);
        do_req(1'b1, 32'h6, 32'hFFFFFFFF, 1, 1'b0);
        do_req(1'b0, 32'h4, 32'h0, 0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 0, 1'b1);

        // Reset two cycles into a write must leave the array untouched
        do_req(1'b1, 32'h20, 32'h12345678, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; addr = 32'h20; wr = 1'b1; din = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_dout", dout, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_back", 32'(ready), 32'd1);
        do_req(1'b0, 32'h20, 32'h0, 0, 1'b0);

        // Randomized traffic over a small index window with random upper bits
        for (int t = 0; t < 40; t++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'b1);
        end

        // Minimum latency instance
        l1_req(1'b1, 32'h8, 32'h0BADF00D, 32'h0);
        l1_req(1'b0, 32'h8, 32'h0, 32'h0BADF00D);
        l1_req(1'b0, 32'h2008, 32'h0, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the multi-cycle CPU. The control unit and datapath act as initiator: they drive a request built from address, read/write and write data. This block is the other end of that interface.
- Accepts one request at a time.
- Models a word-addressed memory array with fixed access latency.
- Returns read data or write completion through a valid/ready response handshake.
- Replaces the zero-latency memory so the sequencer can be exercised with stall states.

Parameters:
DATA_WIDTH, 32, width of a memory word and of din/dout
ADDR_WIDTH, 32, byte-address width
DEPTH_LOG2, 10, log2 of the number of words in the array (1024 words)
LATENCY, 4, cycles from request acceptance to response valid; legal range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
is_input_valid  input  1  request present this cycle
is_ready  output  1  responder can accept a request this cycle
addr  input  ADDR_WIDTH  byte address of the request
mem_write  input  1  1 = write, 0 = read
din  input  DATA_WIDTH  write data
is_output_valid  output  1  response present
is_output_ready  input  1  initiator consumes the response this cycle
dout  output  DATA_WIDTH  read data; 0 for write responses and error responses
is_error  output  1  response belongs to a misaligned request (addr[1:0] != 0)

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, is_output_valid = 0, dout = 0, is_error = 0, latency counter = 0, latched request = 0.
  - is_ready = 0 while reset is high; is_ready = 1 from the first cycle after deassertion.
  - The memory array is not cleared; its contents are undefined until written.
- States: IDLE, ACCESS, RESPOND.
  - is_ready = 1 only in IDLE.
  - is_output_valid = 1 only in RESPOND.
- IDLE:
  - On an edge with is_input_valid & is_ready: latch addr, mem_write and din; load counter = LATENCY-1; go to ACCESS.
  - With is_input_valid low: stay in IDLE.
- ACCESS:
  - Inputs are ignored and is_input_valid is don't-care.
  - Each edge with counter != 0: decrement the counter.
  - Edge with counter == 0, the commit edge:
    - Aligned write: array[index] <= latched din; dout <= 0.
    - Aligned read: dout <= array[index].
    - Misaligned: no array write; dout <= 0; is_error <= 1.
    - Go to RESPOND.
- Timing: a request accepted at edge E0 commits at edge E0+LATENCY. is_output_valid is high in the cycle after E0+LATENCY.
- RESPOND:
  - dout and is_error are held stable while is_output_valid = 1 and is_output_ready = 0.
  - On an edge with is_output_ready = 1: go to IDLE and clear is_output_valid and is_error. dout keeps its last value.
- Minimum spacing between request acceptances is LATENCY+2 cycles; the response handshake edge is not overlapped with a new accept.
- Index = addr[DEPTH_LOG2+1:2]. Address bits above the array size are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2 bytes.
- Read-after-write to the same index returns the newly written word.
- A request presented while is_ready = 0 is ignored and not queued. The initiator must hold it until it is accepted in IDLE.
- Reset mid-operation: an abort before the commit edge leaves the array unmodified for that request. Any pending response is discarded.
- Requests cannot start an ACCESS or RESPOND with is_error from a prior request.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10 with is_output_ready held 1 -> is_output_valid high exactly LATENCY=4 cycles after the accept edge, for 1 cycle; dout = 0, is_error = 0; is_ready returns 1 the next cycle.
- Read 0x10 after that write -> dout = 0xDEADBEEF on the response. A second read with is_output_ready held 0 for 3 cycles -> is_output_valid and dout stay constant for those 3 cycles; is_ready stays 0.
- Write 0x11111111 to 0x0, then read address 0x1000 (wraps to index 0 with DEPTH_LOG2=10) -> dout = 0x11111111.
- Write to 0x6 (misaligned) -> is_error = 1, dout = 0. A subsequent read of 0x4 returns its prior contents unchanged and is_error = 0.
- Assert reset 2 cycles after accepting a write of 0xCAFEF00D to 0x20 that overwrites 0x12345678 -> is_output_valid = 0 immediately. After release, a read of 0x20 returns 0x12345678.
- Toggle is_input_valid with a different address while in ACCESS -> no effect on the response. Repeat with LATENCY=1 -> response valid the cycle after the accept edge.
